sm4_round_key_sequencer: RTL and testbench

//  - Consumer side of the SM4 key-path tau transform. Accepts a 128-bit master key and expands it into
//    32 round keys rk[0..31], one round per cycle. Stores them, then streams them out in order.
//  - Encrypt order is rk[0]..rk[31]; decrypt order is rk[31]..rk[0].
//  - Sits between the key-load interface and the SM4 round datapath, so one engine serves both directions.

---
 rtl/sm4_pkg.sv | 53 +++++
 rtl/sm4_key_round_f.sv | 30 +++
 rtl/sm4_round_key_sequencer.sv | 150 +++++++++++++++
 tb/tb_sm4_round_key_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// SM4 key-schedule constants and shared types.
// Holds the FK system parameters, the CK round constants, the SM4 S-box and
// the key-path linear transform L'. The state enum for the round-key
// sequencer FSM lives here so the top and any tooling see one definition.
package sm4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_SERVE  = 2'd2
  } sm4_state_e;

  localparam logic [31:0] FK [4] = '{
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  // CK[r] byte j (MSB first) = ((4r+j)*7) mod 256
  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // Key-path linear transform: L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
  function automatic logic [31:0] l_prime_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

endpackage

// File: rtl/sm4_key_round_f.sv
// Combinational SM4 key-schedule round function T'.
// Computes L'(tau(K1 ^ K2 ^ K3 ^ CK)), where tau substitutes each byte
// through the SM4 S-box. The caller XORs the result with K0 to form rk.
// Ports:
//   k1_i, k2_i, k3_i : words 1..3 of the key shift register
//   ck_i             : round constant CK[r]
//   t_o              : T' result
module sm4_key_round_f
  import sm4_pkg::*;
(
  input  logic [31:0] k1_i,
  input  logic [31:0] k2_i,
  input  logic [31:0] k3_i,
  input  logic [31:0] ck_i,
  output logic [31:0] t_o
);

  logic [31:0] mix;
  logic [31:0] sub;

  always_comb begin
    mix = k1_i ^ k2_i ^ k3_i ^ ck_i;
    sub = '0;
    for (int j = 0; j < 4; j++) begin
      sub[8*j +: 8] = SBOX[mix[8*j +: 8]];
    end
    t_o = l_prime_key(sub);
  end

endmodule

// File: rtl/sm4_round_key_sequencer.sv
// SM4 round-key sequencer.
// Accepts a 128-bit master key, expands it into 32 round keys at one round
// per cycle into a 32-entry store, then streams the keys out with a
// valid/ready handshake, forward for encryption or reversed for decryption.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   key_valid/key_ready : master-key handshake (ready only in IDLE)
//   key_in              : MK0..MK3, MK0 in the top word
//   decrypt_in          : sampled with the key, selects reverse order
//   rk_valid/rk_ready   : round-key output handshake
//   rk_out, rk_idx      : presented round key and its index i
//   rk_last             : marks the final key of the stream
//   busy                : expanding or serving
module sm4_round_key_sequencer
  import sm4_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ROUNDS     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_valid,
  output logic                        key_ready,
  input  logic [4*WORD_WIDTH-1:0]     key_in,
  input  logic                        decrypt_in,
  output logic                        rk_valid,
  input  logic                        rk_ready,
  output logic [WORD_WIDTH-1:0]       rk_out,
  output logic [$clog2(ROUNDS)-1:0]   rk_idx,
  output logic                        rk_last,
  output logic                        busy
);

  localparam int IDX_W = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

  sm4_state_e             state_q;
  logic [IDX_W-1:0]       round_q;
  logic [IDX_W-1:0]       ptr_q;
  logic                   dec_q;
  logic                   rk_valid_q;
  logic                   rk_last_q;
  logic [WORD_WIDTH-1:0]  rk_out_q;
  logic [IDX_W-1:0]       rk_idx_q;

  logic [WORD_WIDTH-1:0]  k_q [4];
  logic [WORD_WIDTH-1:0]  rk_mem [ROUNDS];

  logic [WORD_WIDTH-1:0]  t_prime;
  logic [WORD_WIDTH-1:0]  rk_new;
  logic [IDX_W-1:0]       ptr_d;
  logic [IDX_W-1:0]       idx_d;
  logic                   key_accept;

  sm4_key_round_f u_round_f (
    .k1_i (k_q[1]),
    .k2_i (k_q[2]),
    .k3_i (k_q[3]),
    .ck_i (CK[round_q]),
    .t_o  (t_prime)
  );

  assign rk_new     = k_q[0] ^ t_prime;
  assign key_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign key_accept = key_valid & key_ready;

  // Next output pointer and the store index it maps to in the chosen order
  assign ptr_d = ptr_q + 1'b1;
  assign idx_d = dec_q ? (LAST - ptr_d) : ptr_d;

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      round_q    <= '0;
      ptr_q      <= '0;
      dec_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            dec_q   <= decrypt_in;
            round_q <= '0;
            state_q <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          round_q <= round_q + 1'b1;
          if (round_q == LAST) begin
            state_q    <= ST_SERVE;
            ptr_q      <= '0;
            rk_valid_q <= 1'b1;
            rk_last_q  <= 1'b0;
            // rk[31] is written on this same edge, so decrypt takes it
            // straight from the round function rather than the store.
            if (dec_q) begin
              rk_out_q <= rk_new;
              rk_idx_q <= LAST;
            end else begin
              rk_out_q <= rk_mem[0];
              rk_idx_q <= '0;
            end
          end
        end
        ST_SERVE: begin
          if (rk_ready) begin
            if (rk_last_q) begin
              state_q    <= ST_IDLE;
              rk_valid_q <= 1'b0;
              rk_last_q  <= 1'b0;
            end else begin
              ptr_q     <= ptr_d;
              rk_idx_q  <= idx_d;
              rk_out_q  <= rk_mem[idx_d];
              rk_last_q <= (ptr_d == LAST);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Key shift register and round-key store carry no reset; contents are
  // only meaningful after a key load.
  always_ff @(posedge clk) begin
    if (key_accept) begin
      for (int i = 0; i < 4; i++) begin
        k_q[i] <= key_in[4*WORD_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH] ^ FK[i];
      end
    end else if (state_q == ST_EXPAND) begin
      rk_mem[round_q] <= rk_new;
      k_q[0] <= k_q[1];
      k_q[1] <= k_q[2];
      k_q[2] <= k_q[3];
      k_q[3] <= rk_new;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_last  = rk_last_q;
  assign rk_out   = rk_out_q;
  assign rk_idx   = rk_idx_q;

endmodule

// File: tb/tb_sm4_round_key_sequencer.sv
// Scoreboard bench for sm4_round_key_sequencer. A behavioural key-schedule
// model fills an expected-stream queue when each key is accepted; a monitor
// compares every output handshake against it.
module tb_sm4_round_key_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic         decrypt_in = 1'b0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [31:0]  rk_out;
  logic [4:0]   rk_idx;
  logic         rk_last;
  logic         busy;

  always #5 clk = ~clk;

  sm4_round_key_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .decrypt_in (decrypt_in),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_out     (rk_out),
    .rk_idx     (rk_idx),
    .rk_last    (rk_last),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] rk;
    logic [4:0]  idx;
    logic        last;
  } ent_t;

  ent_t sb_q[$];
  ent_t got_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_hs_cyc = 0;
  int t_hs = 0;
  bit lat_pend = 1'b0;
  int ready_pct = 100;

  localparam logic [127:0] KEY_A = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY_B = 128'h00112233445566778899AABBCCDDEEFF;

  // S-box rows, row = high nibble
  localparam logic [127:0] SBR [16] = '{
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  localparam logic [31:0] FKT [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

  logic [31:0] ref_rk [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [127:0] row;
    row = SBR[x[7:4]];
    return row[127 - 8*int'(x[3:0]) -: 8];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Straight key schedule: K = MK ^ FK, then 32 rounds over a 4-word window
  task automatic model(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] a, b, ck;
    for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ FKT[i];
    for (int r = 0; r < 32; r++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*r + j) * 7) % 256);
      a = k[r+1] ^ k[r+2] ^ k[r+3] ^ ck;
      for (int j = 0; j < 4; j++) b[8*j +: 8] = sb(a[8*j +: 8]);
      k[r+4] = k[r] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      ref_rk[r] = k[r+4];
    end
  endtask

  // rk_ready generator with adjustable duty
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rk_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: compare each handshake, check stall stability and first-valid latency
  logic        stall_prev = 1'b0;
  logic [31:0] prev_out = '0;
  logic [4:0]  prev_idx = '0;
  always @(negedge clk) begin
    ent_t a, e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && rk_valid) begin
        check("stall_rk_out", rk_out, prev_out);
        check("stall_rk_idx", rk_idx, prev_idx);
      end
      if (lat_pend && rk_valid) begin
        check("latency", cyc - t_hs, 33);
        lat_pend = 1'b0;
      end
      if (rk_valid && rk_ready) begin
        a.rk = rk_out; a.idx = rk_idx; a.last = rk_last;
        got_q.push_back(a);
        hs_cnt++;
        if (rk_last) last_hs_cyc = cyc;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_handshake: rk_out %0h idx %0d with nothing expected", rk_out, rk_idx);
        end else begin
          e = sb_q.pop_front();
          check("rk_out", rk_out, e.rk);
          check("rk_idx", rk_idx, e.idx);
          check("rk_last", rk_last, e.last);
        end
      end
      stall_prev = rk_valid && !rk_ready;
      prev_out = rk_out;
      prev_idx = rk_idx;
    end
  end

  task automatic send_key(input logic [127:0] k, input logic d);
    ent_t e;
    @(posedge clk);
    #1;
    key_valid = 1'b1; key_in = k; decrypt_in = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (key_ready) begin
        model(k);
        for (int p = 0; p < 32; p++) begin
          e.idx = d ? 5'(31 - p) : 5'(p);
          e.rk = ref_rk[e.idx];
          e.last = (p == 31);
          sb_q.push_back(e);
        end
        got_q.delete();
        hs_cnt = 0;
        t_hs = cyc;
        lat_pend = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        return;
      end
    end
    note_timeout("key_accept");
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && key_ready && !rk_valid) begin
        check({name, "_handshakes"}, hs_cnt, 32);
        return;
      end
    end
    note_timeout(name);
    sb_q.delete();
  endtask

  task automatic reset_pulse(input string name);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_rk_valid"}, rk_valid, 0);
    check({name, "_key_ready"}, key_ready, 1);
    check({name, "_busy"}, busy, 0);
    sb_q.delete();
    lat_pend = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rk_valid", rk_valid, 0);
    check("reset_key_ready", key_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_rk_out", rk_out, 0);
    check("reset_rk_idx", rk_idx, 0);
    check("reset_rk_last", rk_last, 0);
    rst_n = 1'b1;

    // Encrypt flow with the published test key
    ready_pct = 100;
    send_key(KEY_A, 1'b0);
    wait_idle("enc");
    check("enc_first_rk", got_q[0].rk, 32'hF12186F9);
    check("enc_first_idx", got_q[0].idx, 0);
    check("enc_second_rk", got_q[1].rk, 32'h41662B61);
    check("enc_last_rk", got_q[31].rk, 32'h9124A012);
    check("enc_last_idx", got_q[31].idx, 31);
    check("enc_last_flag", got_q[31].last, 1);

    // Decrypt flow
    send_key(KEY_A, 1'b1);
    wait_idle("dec");
    check("dec_first_rk", got_q[0].rk, 32'h9124A012);
    check("dec_first_idx", got_q[0].idx, 31);
    check("dec_last_rk", got_q[31].rk, 32'hF12186F9);
    check("dec_last_idx", got_q[31].idx, 0);
    check("dec_last_flag", got_q[31].last, 1);

    // Backpressure at roughly 30% ready
    ready_pct = 30;
    send_key(KEY_A, 1'b0);
    wait_idle("bp");
    check("bp_first_rk", got_q[0].rk, 32'hF12186F9);
    check("bp_last_rk", got_q[31].rk, 32'h9124A012);

    // Busy lockout in EXPAND and SERVE, then back-to-back acceptance
    ready_pct = 50;
    send_key(KEY_A, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    key_valid = 1'b1; key_in = KEY_B; decrypt_in = 1'b1;
    @(negedge clk);
    check("lock_expand_key_ready", key_ready, 0);
    check("lock_expand_busy", busy, 1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = rk_valid;
    end
    if (!seen) note_timeout("lock_wait_serve");
    @(posedge clk);
    #1;
    key_valid = 1'b1; key_in = KEY_B; decrypt_in = 1'b1;
    @(negedge clk);
    check("lock_serve_key_ready", key_ready, 0);
    send_key(KEY_B, 1'b1);
    check("back_to_back_accept", t_hs, last_hs_cyc + 1);
    wait_idle("b2b");

    // Reset during EXPAND at r=10
    ready_pct = 100;
    send_key(KEY_B, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset_pulse("rst_expand");
    send_key(KEY_A, 1'b0);
    wait_idle("after_rst_expand");

    // Reset during SERVE at p=5
    send_key(KEY_A, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = rk_valid && (rk_idx == 5'd5);
    end
    if (!seen) note_timeout("wait_p5");
    reset_pulse("rst_serve");
    send_key(KEY_B, 1'b1);
    wait_idle("after_rst_serve");

    // Randomized keys, directions and ready duty
    for (int it = 0; it < 6; it++) begin
      ready_pct = (it % 3 == 0) ? 100 : ((it % 3 == 1) ? 30 : 70);
      send_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      wait_idle("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
